alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/y86_pkg.sv | 32 +++
 rtl/alu_64.sv | 66 ++++++
 rtl/alu_arbiter.sv | 143 ++++++++++++++
 tb/tb_alu_arbiter.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/y86_pkg.sv
// Shared y86 ALU definitions.
// Holds the ALU opcode encoding, the condition-code bit positions, the
// reset value of the condition codes and a helper that packs the flags.
package y86_pkg;

  // ALU function encoding used on every requester op port
  typedef enum logic [1:0] {
    ALU_ADD = 2'd0,
    ALU_SUB = 2'd1,
    ALU_AND = 2'd2,
    ALU_XOR = 2'd3
  } alu_op_e;

  // Bit positions inside the 3-bit condition-code vector {ZF, SF, OF}
  localparam int CC_ZF = 2;
  localparam int CC_SF = 1;
  localparam int CC_OF = 0;

  // Condition codes after reset: zero flag set, others clear
  localparam logic [2:0] CC_RESET = 3'b100;

  // Place the three flags at their architectural positions
  function automatic logic [2:0] cc_pack(logic zf, logic sf, logic of);
    logic [2:0] c;
    c        = 3'b000;
    c[CC_ZF] = zf;
    c[CC_SF] = sf;
    c[CC_OF] = of;
    return c;
  endfunction

endpackage

// File: rtl/alu_64.sv
// 64-bit combinational ALU with y86 flag generation.
// Ports:
//   op_i     ALU function (ADD, SUB, AND, XOR)
//   a_i, b_i operands; results are b+a, b-a, b&a, b^a (modulo 2^64)
//   result_o 64-bit result
//   zf_o     result is zero
//   sf_o     result sign bit
//   of_o     signed overflow (ADD/SUB only, 0 for logic ops)
module alu_64
  import y86_pkg::*;
(
  input  logic [1:0]  op_i,
  input  logic [63:0] a_i,
  input  logic [63:0] b_i,
  output logic [63:0] result_o,
  output logic        zf_o,
  output logic        sf_o,
  output logic        of_o
);

  logic        is_sub_s;
  logic [63:0] addend_s;
  logic [63:0] sum_s;

  // One shared adder: subtraction is b + ~a + 1
  always_comb begin
    is_sub_s = (op_i == ALU_SUB);
    if (is_sub_s) begin
      addend_s = ~a_i;
    end else begin
      addend_s = a_i;
    end
    sum_s = b_i + addend_s + {63'd0, is_sub_s};
  end

  // Result selection and flag generation
  always_comb begin
    result_o = sum_s;
    of_o     = 1'b0;
    case (op_i)
      ALU_ADD: begin
        result_o = sum_s;
        of_o     = (a_i[63] == b_i[63]) && (sum_s[63] != b_i[63]);
      end
      ALU_SUB: begin
        result_o = sum_s;
        of_o     = (a_i[63] != b_i[63]) && (sum_s[63] != b_i[63]);
      end
      ALU_AND: begin
        result_o = b_i & a_i;
        of_o     = 1'b0;
      end
      ALU_XOR: begin
        result_o = b_i ^ a_i;
        of_o     = 1'b0;
      end
      default: begin
        result_o = sum_s;
        of_o     = 1'b0;
      end
    endcase
    zf_o = (result_o == 64'd0);
    sf_o = result_o[63];
  end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester round-robin arbiter in front of a shared 64-bit ALU.
// One request is accepted per cycle when the single-entry result slot is
// free (empty or being drained this cycle). The result appears one cycle
// after acceptance and is held until the consumer takes it.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   rqN_valid / rqN_ready      request handshake (ready is combinational)
//   rqN_op, rqN_a, rqN_b       ALU function and operands
//   rqN_set_cc                 update condition codes with this result
//   res_valid / res_ready      result handshake
//   res_id, res_value          producing requester and registered result
//   cc                         condition codes {ZF, SF, OF}
module alu_arbiter
  import y86_pkg::*;
#(
  parameter int RR_INIT = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rq0_valid,
  output logic        rq0_ready,
  input  logic [1:0]  rq0_op,
  input  logic [63:0] rq0_a,
  input  logic [63:0] rq0_b,
  input  logic        rq0_set_cc,
  input  logic        rq1_valid,
  output logic        rq1_ready,
  input  logic [1:0]  rq1_op,
  input  logic [63:0] rq1_a,
  input  logic [63:0] rq1_b,
  input  logic        rq1_set_cc,
  output logic        res_valid,
  input  logic        res_ready,
  output logic        res_id,
  output logic [63:0] res_value,
  output logic [2:0]  cc
);

  localparam logic PRIO_INIT = (RR_INIT != 0) ? 1'b1 : 1'b0;

  // Sequential state: priority pointer, result slot, condition codes
  logic        prio_q,      prio_d;
  logic        res_valid_q, res_valid_d;
  logic        res_id_q,    res_id_d;
  logic [63:0] res_value_q, res_value_d;
  logic [2:0]  cc_q,        cc_d;

  logic        slot_free_s;
  logic        grant0_s;
  logic        grant1_s;
  logic        accept_s;
  logic [1:0]  sel_op_s;
  logic [63:0] sel_a_s;
  logic [63:0] sel_b_s;
  logic        sel_set_cc_s;
  logic [63:0] alu_result_s;
  logic        alu_zf_s;
  logic        alu_sf_s;
  logic        alu_of_s;

  // Grant decision; reset forces both grants low so nothing is accepted
  always_comb begin
    slot_free_s = !res_valid_q || res_ready;
    grant0_s    = !reset && slot_free_s && rq0_valid && (!rq1_valid || (prio_q == 1'b0));
    grant1_s    = !reset && slot_free_s && rq1_valid && (!rq0_valid || (prio_q == 1'b1));
    accept_s    = grant0_s || grant1_s;
  end

  // Operand multiplexer feeding the single ALU instance
  always_comb begin
    if (grant1_s) begin
      sel_op_s     = rq1_op;
      sel_a_s      = rq1_a;
      sel_b_s      = rq1_b;
      sel_set_cc_s = rq1_set_cc;
    end else begin
      sel_op_s     = rq0_op;
      sel_a_s      = rq0_a;
      sel_b_s      = rq0_b;
      sel_set_cc_s = rq0_set_cc;
    end
  end

  alu_64 u_alu (
    .op_i     (sel_op_s),
    .a_i      (sel_a_s),
    .b_i      (sel_b_s),
    .result_o (alu_result_s),
    .zf_o     (alu_zf_s),
    .sf_o     (alu_sf_s),
    .of_o     (alu_of_s)
  );

  // Next-state for priority, result slot and condition codes
  always_comb begin
    prio_d      = prio_q;
    res_valid_d = res_valid_q;
    res_id_d    = res_id_q;
    res_value_d = res_value_q;
    cc_d        = cc_q;
    if (accept_s) begin
      // Load wins over drain, giving one result per cycle back-to-back
      res_valid_d = 1'b1;
      res_id_d    = grant1_s;
      res_value_d = alu_result_s;
      prio_d      = !grant1_s;
      if (sel_set_cc_s) begin
        cc_d = cc_pack(alu_zf_s, alu_sf_s, alu_of_s);
      end else begin
        cc_d = cc_q;
      end
    end else if (res_ready) begin
      res_valid_d = 1'b0;
    end else begin
      res_valid_d = res_valid_q;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      prio_q      <= PRIO_INIT;
      res_valid_q <= 1'b0;
      res_id_q    <= 1'b0;
      res_value_q <= 64'd0;
      cc_q        <= CC_RESET;
    end else begin
      prio_q      <= prio_d;
      res_valid_q <= res_valid_d;
      res_id_q    <= res_id_d;
      res_value_q <= res_value_d;
      cc_q        <= cc_d;
    end
  end

  assign rq0_ready = grant0_s;
  assign rq1_ready = grant1_s;
  assign res_valid = res_valid_q;
  assign res_id    = res_id_q;
  assign res_value = res_value_q;
  assign cc        = cc_q;

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        rq0_valid, rq1_valid;
  logic        rq0_ready, rq1_ready;
  logic [1:0]  rq0_op, rq1_op;
  logic [63:0] rq0_a, rq0_b, rq1_a, rq1_b;
  logic        rq0_set_cc, rq1_set_cc;
  logic        res_valid, res_ready, res_id;
  logic [63:0] res_value;
  logic [2:0]  cc;

  always #5 clk = ~clk;

  alu_arbiter #(.RR_INIT(0)) dut (
    .clk(clk), .reset(reset),
    .rq0_valid(rq0_valid), .rq0_ready(rq0_ready), .rq0_op(rq0_op),
    .rq0_a(rq0_a), .rq0_b(rq0_b), .rq0_set_cc(rq0_set_cc),
    .rq1_valid(rq1_valid), .rq1_ready(rq1_ready), .rq1_op(rq1_op),
    .rq1_a(rq1_a), .rq1_b(rq1_b), .rq1_set_cc(rq1_set_cc),
    .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id),
    .res_value(res_value), .cc(cc)
  );

  typedef struct {
    logic        id;
    logic [63:0] value;
  } exp_t;

  typedef struct {
    logic        id;
    logic [1:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic        sc;
    logic [63:0] ev;
    logic [2:0]  ecc;
  } vec_t;

  exp_t        sb_q[$];
  vec_t        tab[10];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic        prio_m;
  logic [2:0]  cc_m;
  logic        obs_r0, obs_r1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Independent reference: 65-bit signed arithmetic detects overflow
  task automatic ref_alu(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b,
                         output logic [63:0] v, output logic [2:0] f);
    logic signed [64:0] ea, eb, s;
    logic of;
    ea = {a[63], a};
    eb = {b[63], b};
    of = 1'b0;
    case (op)
      2'd0: begin s = eb + ea; v = s[63:0]; of = s[64] ^ s[63]; end
      2'd1: begin s = eb - ea; v = s[63:0]; of = s[64] ^ s[63]; end
      2'd2: v = b & a;
      default: v = b ^ a;
    endcase
    f = {(v == 64'd0), v[63], of};
  endtask

  task automatic idle_inputs();
    rq0_valid = 1'b0; rq1_valid = 1'b0;
    rq0_op = 2'd0; rq1_op = 2'd0;
    rq0_a = 64'd0; rq0_b = 64'd0; rq1_a = 64'd0; rq1_b = 64'd0;
    rq0_set_cc = 1'b0; rq1_set_cc = 1'b0;
  endtask

  task automatic drive(input logic id, input logic [1:0] op, input logic [63:0] a,
                       input logic [63:0] b, input logic sc);
    if (id) begin
      rq1_valid = 1'b1; rq1_op = op; rq1_a = a; rq1_b = b; rq1_set_cc = sc;
    end else begin
      rq0_valid = 1'b1; rq0_op = op; rq0_a = a; rq0_b = b; rq0_set_cc = sc;
    end
  endtask

  // One clock: check handshakes and outputs, update scoreboard and model.
  // Called just after a falling edge with inputs already driven.
  task automatic cycle(input logic use_tab, input logic [63:0] tv, input logic [2:0] tcc);
    logic vld_m, free_m, g0, g1;
    logic [63:0] v;
    logic [2:0] f;
    exp_t e;
    #1;
    vld_m  = (sb_q.size() != 0);
    free_m = !vld_m || res_ready;
    g0 = free_m && rq0_valid && (!rq1_valid || !prio_m);
    g1 = free_m && rq1_valid && (!rq0_valid || prio_m);
    obs_r0 = rq0_ready;
    obs_r1 = rq1_ready;
    check("rq0_ready", {63'd0, rq0_ready}, {63'd0, g0});
    check("rq1_ready", {63'd0, rq1_ready}, {63'd0, g1});
    check("res_valid", {63'd0, res_valid}, {63'd0, vld_m});
    check("cc", {61'd0, cc}, {61'd0, cc_m});
    if (vld_m) begin
      check("res_id", {63'd0, res_id}, {63'd0, sb_q[0].id});
      check("res_value", res_value, sb_q[0].value);
      if (res_ready) void'(sb_q.pop_front());
    end
    if (g0 || g1) begin
      if (g1) ref_alu(rq1_op, rq1_a, rq1_b, v, f);
      else    ref_alu(rq0_op, rq0_a, rq0_b, v, f);
      if (use_tab) begin
        v = tv;
        f = tcc;
      end
      e.id = g1;
      e.value = v;
      sb_q.push_back(e);
      if ((g1 && rq1_set_cc) || (g0 && rq0_set_cc) || use_tab) cc_m = f;
      prio_m = g0;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    rq0_valid = 1'b1; rq1_valid = 1'b1; res_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      check("reset_rq0_ready", {63'd0, rq0_ready}, 64'd0);
      check("reset_rq1_ready", {63'd0, rq1_ready}, 64'd0);
      @(posedge clk);
      @(negedge clk);
    end
    check("reset_res_valid", {63'd0, res_valid}, 64'd0);
    check("reset_res_id", {63'd0, res_id}, 64'd0);
    check("reset_res_value", res_value, 64'd0);
    check("reset_cc", {61'd0, cc}, {61'd0, 3'b100});
    reset = 1'b0;
    idle_inputs();
    sb_q.delete();
    prio_m = 1'b0;
    cc_m = 3'b100;
  endtask

  initial begin
    logic [3:0] seq;
    reset = 1'b1;
    res_ready = 1'b0;
    idle_inputs();
    // id, op, a, b, set_cc, expected value, expected cc after
    tab[0] = '{1'b0, 2'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 3'b011};
    tab[1] = '{1'b1, 2'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 3'b010};
    tab[2] = '{1'b1, 2'd0, 64'h8000_0000_0000_0001, 64'h8000_0000_0000_0001, 1'b1, 64'h2, 3'b001};
    tab[3] = '{1'b0, 2'd1, 64'd5, 64'd5, 1'b0, 64'd0, 3'b001};
    tab[4] = '{1'b0, 2'd1, 64'd5, 64'd5, 1'b1, 64'd0, 3'b100};
    tab[5] = '{1'b1, 2'd2, 64'hF0F0, 64'hFF00, 1'b1, 64'hF000, 3'b000};
    tab[6] = '{1'b0, 2'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 3'b010};
    tab[7] = '{1'b1, 2'd1, 64'd1, 64'h8000_0000_0000_0000, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 3'b001};
    tab[8] = '{1'b0, 2'd1, 64'h8000_0000_0000_0000, 64'd0, 1'b1, 64'h8000_0000_0000_0000, 3'b011};
    tab[9] = '{1'b0, 2'd0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 64'd0, 3'b011};
    @(negedge clk);
    do_reset();

    // Idle after reset
    res_ready = 1'b1;
    for (int i = 0; i < 2; i++) cycle(1'b0, 64'd0, 3'b000);

    // Directed ALU vectors, one per cycle, back-to-back
    for (int i = 0; i < 10; i++) begin
      idle_inputs();
      drive(tab[i].id, tab[i].op, tab[i].a, tab[i].b, tab[i].sc);
      cycle(1'b1, tab[i].ev, tab[i].ecc);
    end
    idle_inputs();
    cycle(1'b0, 64'd0, 3'b000);

    // Round robin from reset priority: grants 0,1,0,1
    do_reset();
    res_ready = 1'b1;
    seq = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 2'd0, 64'(i), 64'd100, 1'b0);
      drive(1'b1, 2'd0, 64'(i), 64'd200, 1'b0);
      cycle(1'b0, 64'd0, 3'b000);
      check("rr_grant1", {63'd0, obs_r1}, {63'd0, seq[i]});
      check("rr_grant0", {63'd0, obs_r0}, {63'd0, ~seq[i]});
    end
    idle_inputs();
    cycle(1'b0, 64'd0, 3'b000);

    // Backpressure: pending result blocks a new request, operands ignored
    drive(1'b0, 2'd0, 64'd1, 64'd2, 1'b1);
    cycle(1'b0, 64'd0, 3'b000);
    res_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 2'd1, 64'(i + 7), 64'd50, 1'b1);
      cycle(1'b0, 64'd0, 3'b000);
      check("stall_rq0_ready", {63'd0, obs_r0}, 64'd0);
    end
    res_ready = 1'b1;
    drive(1'b0, 2'd0, 64'd10, 64'd20, 1'b1);
    cycle(1'b1, 64'd30, 3'b000);
    check("drain_accept", {63'd0, obs_r0}, 64'd1);
    idle_inputs();
    cycle(1'b0, 64'd0, 3'b000);

    // Reset discards a pending result
    drive(1'b1, 2'd3, 64'h55, 64'hAA, 1'b1);
    cycle(1'b0, 64'd0, 3'b000);
    idle_inputs();
    res_ready = 1'b0;
    cycle(1'b0, 64'd0, 3'b000);
    do_reset();

    // Random traffic with random backpressure
    for (int i = 0; i < 300; i++) begin
      idle_inputs();
      res_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 2) != 0)
        drive(1'b0, 2'($urandom_range(0, 3)), {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 2) != 0)
        drive(1'b1, 2'($urandom_range(0, 3)), {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(0, 1)));
      cycle(1'b0, 64'd0, 3'b000);
    end
    idle_inputs();
    res_ready = 1'b1;
    for (int i = 0; i < 2; i++) cycle(1'b0, 64'd0, 3'b000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
